// File: rtl/memory_stage.sv
// Memory-access stage: owns the 16-bit data memory and the stack pointer.
// Handles word loads/stores, 16-bit stack push/pop, flags push/pop and the
// two-cycle 32-bit PC push/pop, and registers the MEM/WB fields.
//
// Handshake: Stall is a combinational hold request to everything upstream.
// While Stall=1, EX/MEM holds its fields stable and the stage consumes them
// again on the next edge. Stall rises only in IDLE with a 32-bit stack op
// present, so each such op stalls for exactly one cycle.
module memory_stage #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MR,
  input  logic              MW,
  input  logic              WB,
  input  logic              JWSP,
  input  logic              Stack_PC,
  input  logic              Stack_Flags,
  input  logic [2:0]        WB_Address,
  input  logic [31:0]       Data,
  input  logic [31:0]       Address,
  input  logic [2:0]        Flags,
  output logic              Stall,
  output logic              WB_Out,
  output logic [2:0]        WB_Address_Out,
  output logic [15:0]       WB_Data_Out,
  output logic [31:0]       PC_Out,
  output logic              PC_Valid,
  output logic [2:0]        Flags_From_Memory,
  output logic              Flags_Valid,
  output logic [ADDR_W-1:0] SP_Out
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SECOND = 1'b1} state_t;

  logic [15:0]       r_mem [0:(1<<ADDR_W)-1];
  state_t            r_state;
  logic [ADDR_W-1:0] r_sp;
  logic [15:0]       r_pc_low;

  logic              w_pc_op;
  logic              w_flags_op;
  logic              w_rd_only;
  logic [ADDR_W-1:0] w_sp_inc;
  logic [ADDR_W-1:0] w_sp_dec;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;
  logic [15:0]       w_wdata;
  logic [15:0]       w_rdata;
  logic              w_unused;

  // Upper address bits fall outside the memory and are ignored.
  assign w_unused = ^Address[31:ADDR_W];

  // Stack-op classification; Stack_PC takes priority over Stack_Flags.
  assign w_pc_op    = JWSP && Stack_PC && (MR || MW);
  assign w_flags_op = JWSP && Stack_Flags && !Stack_PC && (MR || MW);
  // A read with no write: when both MR and MW are set, the write wins.
  assign w_rd_only  = MR && !MW;

  // SP arithmetic wraps modulo the memory depth by width truncation.
  assign w_sp_inc = r_sp + 1'b1;
  assign w_sp_dec = r_sp - 1'b1;

  // Stack accesses address through SP; pushes write at SP, pops read SP+1.
  assign w_waddr = JWSP ? r_sp     : Address[ADDR_W-1:0];
  assign w_raddr = JWSP ? w_sp_inc : Address[ADDR_W-1:0];
  assign w_rdata = r_mem[w_raddr];

  // Stall only for the first cycle of a 32-bit op, never while in reset.
  assign Stall = !rst && (r_state == ST_IDLE) && w_pc_op;

  assign SP_Out = r_sp;

  // Select the word to store: PC high then low half, flags, or plain data.
  always_comb begin
    w_wdata = Data[15:0];
    if (w_pc_op) begin
      w_wdata = (r_state == ST_IDLE) ? Data[31:16] : Data[15:0];
    end else if (w_flags_op) begin
      w_wdata = {13'b0, Flags};
    end
  end

  // Memory write port; gated by rst so a reset aborts a pending write.
  always_ff @(posedge clk) begin
    if (!rst && MW) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Stage FSM, SP and registered MEM/WB outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_sp              <= SP_RESET;
      r_pc_low          <= '0;
      WB_Out            <= 1'b0;
      WB_Address_Out    <= '0;
      WB_Data_Out       <= '0;
      PC_Out            <= '0;
      PC_Valid          <= 1'b0;
      Flags_From_Memory <= '0;
      Flags_Valid       <= 1'b0;
    end else begin
      PC_Valid    <= 1'b0;
      Flags_Valid <= 1'b0;
      if (w_pc_op && (r_state == ST_IDLE)) begin
        // First half of a PC op: bubble into MEM/WB.
        r_state        <= ST_SECOND;
        WB_Out         <= 1'b0;
        WB_Address_Out <= '0;
        WB_Data_Out    <= '0;
        if (MW) begin
          r_sp <= w_sp_dec;
        end else begin
          r_sp     <= w_sp_inc;
          r_pc_low <= w_rdata;
        end
      end else if (w_pc_op) begin
        // Second half: finish the PC op and retire the instruction.
        r_state        <= ST_IDLE;
        WB_Out         <= WB;
        WB_Address_Out <= WB_Address;
        WB_Data_Out    <= Data[15:0];
        if (MW) begin
          r_sp <= w_sp_dec;
        end else begin
          r_sp     <= w_sp_inc;
          PC_Out   <= {w_rdata, r_pc_low};
          PC_Valid <= 1'b1;
        end
      end else begin
        r_state        <= ST_IDLE;
        WB_Out         <= WB;
        WB_Address_Out <= WB_Address;
        if (MR && MW) begin
          WB_Data_Out <= '0;
        end else if (MR && !w_flags_op) begin
          WB_Data_Out <= w_rdata;
        end else begin
          WB_Data_Out <= Data[15:0];
        end
        if (JWSP && MW) begin
          r_sp <= w_sp_dec;
        end else if (JWSP && w_rd_only) begin
          r_sp <= w_sp_inc;
        end
        if (w_flags_op && w_rd_only) begin
          Flags_From_Memory <= w_rdata[2:0];
          Flags_Valid       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: reset, load/store, stack push/pop,
// PC and flags stack ops, priority, wrap-around and reset mid-op.
module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic        mr, mw, wb, jwsp, stack_pc, stack_flags;
  logic [2:0]  wb_address;
  logic [31:0] data;
  logic [31:0] address;
  logic [2:0]  flags;
  logic        stall;
  logic        wb_out;
  logic [2:0]  wb_address_out;
  logic [15:0] wb_data_out;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [2:0]  flags_from_memory;
  logic        flags_valid;
  logic [11:0] sp_out;

  int n_vec;
  int n_err;

  memory_stage #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .MR(mr), .MW(mw), .WB(wb), .JWSP(jwsp),
    .Stack_PC(stack_pc), .Stack_Flags(stack_flags), .WB_Address(wb_address),
    .Data(data), .Address(address), .Flags(flags), .Stall(stall),
    .WB_Out(wb_out), .WB_Address_Out(wb_address_out), .WB_Data_Out(wb_data_out),
    .PC_Out(pc_out), .PC_Valid(pc_valid), .Flags_From_Memory(flags_from_memory),
    .Flags_Valid(flags_valid), .SP_Out(sp_out)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i_mr, input logic i_mw, input logic i_wb,
                       input logic i_jwsp, input logic i_spc, input logic i_sfl,
                       input logic [2:0] i_wba, input logic [31:0] i_data,
                       input logic [31:0] i_addr, input logic [2:0] i_flags);
    mr = i_mr; mw = i_mw; wb = i_wb; jwsp = i_jwsp;
    stack_pc = i_spc; stack_flags = i_sfl; wb_address = i_wba;
    data = i_data; address = i_addr; flags = i_flags;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 3'd0);
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    tick(); tick();
    n_vec++;
    if (sp_out !== 12'd4095) begin
      $display("FAIL reset_sp: got %0d expected 4095", sp_out); n_err++;
    end
    n_vec++;
    if ({wb_out, wb_address_out, wb_data_out, pc_out, pc_valid, flags_from_memory, flags_valid, stall} !== '0) begin
      $display("FAIL reset_outputs: got wb=%b wba=%0d wbd=%h pc=%h pcv=%b fl=%b flv=%b stall=%b expected all 0",
               wb_out, wb_address_out, wb_data_out, pc_out, pc_valid, flags_from_memory, flags_valid, stall);
      n_err++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    drive(0, 1, 0, 0, 0, 0, 3'd0, 32'h0000BEEF, 32'h10, 3'd0);
    tick();
    drive(1, 0, 1, 0, 0, 0, 3'd3, 32'h0, 32'h10, 3'd0);
    tick();
    n_vec++;
    if (wb_data_out !== 16'hBEEF || wb_out !== 1'b1 || wb_address_out !== 3'd3) begin
      $display("FAIL store_load: got data=%h wb=%b wba=%0d expected BEEF 1 3", wb_data_out, wb_out, wb_address_out);
      n_err++;
    end
    // Non-memory instruction passes Data[15:0] through.
    drive(0, 0, 1, 0, 0, 0, 3'd5, 32'h1234ABCD, 32'h0, 3'd0);
    tick();
    n_vec++;
    if (wb_data_out !== 16'hABCD || wb_out !== 1'b1 || wb_address_out !== 3'd5) begin
      $display("FAIL passthrough: got data=%h wb=%b wba=%0d expected ABCD 1 5", wb_data_out, wb_out, wb_address_out);
      n_err++;
    end
  endtask

  task automatic test_push_pop();
    drive(0, 1, 0, 1, 0, 0, 3'd0, 32'h00001234, 32'h0, 3'd0);
    tick();
    n_vec++;
    if (sp_out !== 12'd4094) begin
      $display("FAIL push_sp: got %0d expected 4094", sp_out); n_err++;
    end
    drive(1, 0, 1, 1, 0, 0, 3'd2, 32'h0, 32'h0, 3'd0);
    tick();
    n_vec++;
    if (wb_data_out !== 16'h1234 || sp_out !== 12'd4095 || wb_out !== 1'b1) begin
      $display("FAIL pop: got data=%h sp=%0d wb=%b expected 1234 4095 1", wb_data_out, sp_out, wb_out);
      n_err++;
    end
  endtask

  task automatic test_pc_push_pop();
    drive(0, 1, 1, 1, 1, 0, 3'd1, 32'hAABBCCDD, 32'h0, 3'd0);
    #1;
    n_vec++;
    if (stall !== 1'b1) begin
      $display("FAIL pc_push_stall1: got %b expected 1", stall); n_err++;
    end
    tick();
    n_vec++;
    if (stall !== 1'b0 || wb_out !== 1'b0 || sp_out !== 12'd4094) begin
      $display("FAIL pc_push_second: got stall=%b wb=%b sp=%0d expected 0 0 4094", stall, wb_out, sp_out);
      n_err++;
    end
    tick();
    n_vec++;
    if (sp_out !== 12'd4093) begin
      $display("FAIL pc_push_sp: got %0d expected 4093", sp_out); n_err++;
    end
    drive(1, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'd4095, 3'd0);
    tick();
    n_vec++;
    if (wb_data_out !== 16'hAABB) begin
      $display("FAIL pc_push_hi: got %h expected AABB", wb_data_out); n_err++;
    end
    drive(1, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'd4094, 3'd0);
    tick();
    n_vec++;
    if (wb_data_out !== 16'hCCDD) begin
      $display("FAIL pc_push_lo: got %h expected CCDD", wb_data_out); n_err++;
    end
    drive(1, 0, 0, 1, 1, 0, 3'd0, 32'h0, 32'h0, 3'd0);
    #1;
    n_vec++;
    if (stall !== 1'b1) begin
      $display("FAIL pc_pop_stall1: got %b expected 1", stall); n_err++;
    end
    tick();
    n_vec++;
    if (stall !== 1'b0 || pc_valid !== 1'b0 || sp_out !== 12'd4094) begin
      $display("FAIL pc_pop_second: got stall=%b pcv=%b sp=%0d expected 0 0 4094", stall, pc_valid, sp_out);
      n_err++;
    end
    tick();
    n_vec++;
    if (pc_out !== 32'hAABBCCDD || pc_valid !== 1'b1 || sp_out !== 12'd4095) begin
      $display("FAIL pc_pop: got pc=%h pcv=%b sp=%0d expected AABBCCDD 1 4095", pc_out, pc_valid, sp_out);
      n_err++;
    end
    idle_in();
    tick();
    n_vec++;
    if (pc_valid !== 1'b0 || pc_out !== 32'hAABBCCDD) begin
      $display("FAIL pc_valid_pulse: got pcv=%b pc=%h expected 0 AABBCCDD", pc_valid, pc_out); n_err++;
    end
  endtask

  task automatic test_reset_mid_op();
    drive(0, 1, 0, 0, 0, 0, 3'd0, 32'h00005A5A, 32'd4094, 3'd0);
    tick();
    drive(0, 1, 1, 1, 1, 0, 3'd4, 32'h11223344, 32'h0, 3'd0);
    tick();
    // Now in the SECOND cycle of the PC push.
    rst = 1'b1;
    #1;
    n_vec++;
    if (sp_out !== 12'd4095 || stall !== 1'b0 || pc_valid !== 1'b0) begin
      $display("FAIL midop_reset: got sp=%0d stall=%b pcv=%b expected 4095 0 0", sp_out, stall, pc_valid);
      n_err++;
    end
    n_vec++;
    if ({wb_out, wb_address_out, wb_data_out, pc_out, flags_from_memory, flags_valid} !== '0) begin
      $display("FAIL midop_outputs: got wb=%b wba=%0d wbd=%h pc=%h fl=%b flv=%b expected all 0",
               wb_out, wb_address_out, wb_data_out, pc_out, flags_from_memory, flags_valid);
      n_err++;
    end
    tick();
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'd4094, 3'd0);
    tick();
    n_vec++;
    if (wb_data_out !== 16'h5A5A || sp_out !== 12'd4095) begin
      $display("FAIL midop_mem: got mem=%h sp=%0d expected 5A5A 4095", wb_data_out, sp_out); n_err++;
    end
  endtask

  task automatic test_flags();
    drive(0, 1, 0, 1, 0, 1, 3'd0, 32'h0, 32'h0, 3'b101);
    tick();
    drive(1, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'd4095, 3'd0);
    tick();
    n_vec++;
    if (wb_data_out !== 16'h0005 || sp_out !== 12'd4094) begin
      $display("FAIL flags_push: got mem=%h sp=%0d expected 0005 4094", wb_data_out, sp_out); n_err++;
    end
    drive(1, 0, 0, 1, 0, 1, 3'd0, 32'h0, 32'h0, 3'd0);
    tick();
    n_vec++;
    if (flags_from_memory !== 3'b101 || flags_valid !== 1'b1 || sp_out !== 12'd4095) begin
      $display("FAIL flags_pop: got fl=%b flv=%b sp=%0d expected 101 1 4095", flags_from_memory, flags_valid, sp_out);
      n_err++;
    end
    idle_in();
    tick();
    n_vec++;
    if (flags_valid !== 1'b0) begin
      $display("FAIL flags_valid_pulse: got %b expected 0", flags_valid); n_err++;
    end
  endtask

  task automatic test_both_rw();
    drive(1, 1, 1, 0, 0, 0, 3'd6, 32'h00007777, 32'h20, 3'd0);
    tick();
    n_vec++;
    if (wb_data_out !== 16'h0000 || sp_out !== 12'd4095) begin
      $display("FAIL both_rw: got data=%h sp=%0d expected 0000 4095", wb_data_out, sp_out); n_err++;
    end
    drive(1, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h20, 3'd0);
    tick();
    n_vec++;
    if (wb_data_out !== 16'h7777) begin
      $display("FAIL both_rw_write: got %h expected 7777", wb_data_out); n_err++;
    end
  endtask

  task automatic test_pc_flags_priority();
    drive(0, 1, 0, 1, 1, 1, 3'd0, 32'h11112222, 32'h0, 3'b111);
    tick(); tick();
    drive(1, 1'b0, 0, 1, 1, 1, 3'd0, 32'h0, 32'h0, 3'd0);
    tick(); tick();
    n_vec++;
    if (pc_out !== 32'h11112222 || pc_valid !== 1'b1 || flags_valid !== 1'b0 || sp_out !== 12'd4095) begin
      $display("FAIL pc_priority: got pc=%h pcv=%b flv=%b sp=%0d expected 11112222 1 0 4095",
               pc_out, pc_valid, flags_valid, sp_out);
      n_err++;
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4095; i++) begin
      drive(0, 1, 0, 1, 0, 0, 3'd0, i, 32'h0, 3'd0);
      tick();
    end
    n_vec++;
    if (sp_out !== 12'd0) begin
      $display("FAIL wrap_sp0: got %0d expected 0", sp_out); n_err++;
    end
    drive(0, 1, 0, 1, 0, 0, 3'd0, 32'h00000BAD, 32'h0, 3'd0);
    tick();
    n_vec++;
    if (sp_out !== 12'd4095) begin
      $display("FAIL wrap_push: got %0d expected 4095", sp_out); n_err++;
    end
    drive(1, 0, 1, 1, 0, 0, 3'd7, 32'h0, 32'h0, 3'd0);
    tick();
    n_vec++;
    if (wb_data_out !== 16'h0BAD || sp_out !== 12'd0) begin
      $display("FAIL wrap_pop: got data=%h sp=%0d expected 0BAD 0", wb_data_out, sp_out); n_err++;
    end
    tick();
    n_vec++;
    if (wb_data_out !== 16'h0FFE || sp_out !== 12'd1) begin
      $display("FAIL wrap_pop2: got data=%h sp=%0d expected 0FFE 1", wb_data_out, sp_out); n_err++;
    end
    idle_in();
    tick();
  endtask

  // Sequence of scenarios, then the final report.
  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    idle_in();
    #1;
    test_reset();
    test_store_load();
    test_push_pop();
    test_pc_push_pop();
    test_reset_mid_op();
    test_flags();
    test_both_rw();
    test_pc_flags_priority();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
